wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage between the MEM stage and the register file write port.
//  Holds one retiring instruction and waits for the data-memory response on loads.
//  Sign/zero-extends load data and drives the regfile write port (wr_en/wr_addr/wr_data).
//  Back-pressures MEM via in_ready and counts retired instructions.
// PARAMETERS
//  XLEN   32  data width of results and memory response
//  CNT_W  64  width of retired-instruction counter
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous, active-high reset
//  in_valid      in   1      MEM stage presents an instruction
//  in_ready      out  1      stage accepts the instruction this cycle
//  in_is_load    in   1      instruction is a load; result comes from mem_rsp_data
//  in_funct3     in   3      load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
//  in_byte_off   in   2      low address bits of the load
//  in_reg_wr     in   1      instruction writes rd
//  in_rd         in   5      destination register
//  in_result     in   XLEN   ALU/CSR/link result for non-loads
//  mem_rsp_valid in   1      data-memory read response valid (one-cycle pulse)
//  mem_rsp_data  in   XLEN   aligned 32-bit word containing the loaded bytes
//  wr_en         out  1      regfile write enable
//  wr_addr       out  5      regfile write address
//  wr_data       out  XLEN   regfile write data
//  retire        out  1      one-cycle pulse per retired instruction
//  instret       out  CNT_W  retired-instruction count
// BEHAVIOUR
//  FSM states: IDLE, WAIT_MEM, COMMIT. Reset -> IDLE.
//  Reset values: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, retire=0, instret=0.
//  in_ready = (state==IDLE) || (state==COMMIT). Accept = in_valid && in_ready.
//  IDLE/COMMIT on accept: non-load -> COMMIT, data=in_result; load -> WAIT_MEM.
//  IDLE/COMMIT with no accept -> IDLE.
//  Accept captures rd, reg_wr, funct3, byte_off.
//  WAIT_MEM: in_ready=0. mem_rsp_valid -> capture extended data -> COMMIT; else stay.
//  mem_rsp_valid is ignored outside WAIT_MEM (including the accept cycle itself).
//  COMMIT lasts exactly one cycle. Outputs are Moore, decoded from registered state:
//   wr_en  = held reg_wr && held rd != 0.
//   wr_addr = held rd; wr_data = held data; retire = 1.
//  Outside COMMIT: wr_en=0 and retire=0. wr_addr/wr_data keep their last value.
//  Latency:
//   non-load accepted in cycle N -> write in cycle N+1;
//   load response in cycle M -> write in cycle M+1.
//  Back-to-back non-loads retire one per cycle (accept in COMMIT).
//  Load extension: byte = word[8*off +: 8]; half = word[16*off[1] +: 16]; off[0] ignored for halves.
//   LB/LH sign-extend; LBU/LHU zero-extend; LW ignores offset.
//   funct3 011/110/111 are treated as LW.
//  instret += 1 in every COMMIT cycle, including rd==x0 and reg_wr==0; wraps at 2^CNT_W.
//  Reset mid-load (WAIT_MEM): pending load is dropped, no write, instret=0.
//   A late mem_rsp_valid after reset is ignored.
// TESTING
//  1. Reset, then in_valid non-load rd=5 result=0x1234 in cycle 1
//     -> cycle 2: wr_en=1, wr_addr=5, wr_data=0x1234, retire=1, instret=1.
//  2. Three back-to-back non-loads (rd=1,2,3) -> in_ready stays 1.
//     Writes occur in 3 consecutive cycles; instret=3.
//  3. LB off=3 with rsp 0x80FF_0000 delayed 4 cycles -> in_ready=0 for 4 cycles.
//     Then wr_data=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
//  4. LH off=2 rsp 0x8001_7FFF -> 0xFFFF_8001. LHU off=0 -> 0x0000_7FFF. LW off=1 -> 0x8001_7FFF.
//  5. Non-load rd=0 result=0xDEAD -> wr_en=0, retire=1, instret increments.
//     reg_wr=0 rd=7 -> wr_en=0.
//  6. rst asserted in WAIT_MEM, then mem_rsp_valid -> no write, state IDLE, instret=0, in_ready=1.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, waits for load data on loads, drives the regfile write port.
// Non-loads write the cycle after accept, loads the cycle after the response; in_ready is low while a load waits.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_byte_off,
  input  logic             in_reg_wr,
  input  logic [4:0]       in_rd,
  input  logic [XLEN-1:0]  in_result,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rsp_data,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [XLEN-1:0]  wr_data,
  output logic             retire,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  typedef struct packed {
    logic       reg_wr;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] byte_off;
  } hdr_t;

  state_t state;
  hdr_t   hdr;
  logic   accept;

  assign in_ready = (state != WAIT_MEM);
  assign accept   = in_valid && in_ready;

  // Halfword select uses only off[1]; unsupported funct3 codes return the whole word.
  function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      f3,
                                               input logic [1:0]      off,
                                               input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
      3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
      default: load_ext = word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hdr     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      retire  <= 1'b0;
      instret <= '0;
    end else begin
      wr_en  <= 1'b0;
      retire <= 1'b0;
      case (state)
        WAIT_MEM: begin
          if (mem_rsp_valid) begin
            state   <= COMMIT;
            wr_en   <= hdr.reg_wr && (hdr.rd != 5'd0);
            wr_addr <= hdr.rd;
            wr_data <= load_ext(hdr.funct3, hdr.byte_off, mem_rsp_data);
            retire  <= 1'b1;
            instret <= instret + CNT_W'(1);
          end
        end
        default: begin
          if (accept) begin
            hdr <= '{reg_wr: in_reg_wr, rd: in_rd, funct3: in_funct3, byte_off: in_byte_off};
            if (in_is_load) begin
              state <= WAIT_MEM;
            end else begin
              state   <= COMMIT;
              wr_en   <= in_reg_wr && (in_rd != 5'd0);
              wr_addr <= in_rd;
              wr_data <= in_result;
              retire  <= 1'b1;
              instret <= instret + CNT_W'(1);
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writes queued at issue, compared when retire pulses.
module tb_wb_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_is_load;
  logic [2:0]       in_funct3;
  logic [1:0]       in_byte_off;
  logic             in_reg_wr;
  logic [4:0]       in_rd;
  logic [XLEN-1:0]  in_result;
  logic             mem_rsp_valid;
  logic [XLEN-1:0]  mem_rsp_data;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [XLEN-1:0]  wr_data;
  logic             retire;
  logic [CNT_W-1:0] instret;

  wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_byte_off(in_byte_off), .in_reg_wr(in_reg_wr),
    .in_rd(in_rd), .in_result(in_result),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .retire(retire), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            en;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks    = 0;
  int  passed    = 0;
  int  fails     = 0;
  int  model_cnt = 0;
  bit  started   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every retire pops one expected write; no retire means no write.
  always @(negedge clk) begin
    if (started && !rst) begin
      if (retire) begin
        model_cnt = model_cnt + 1;
        check("instret_at_retire", instret, 64'(model_cnt));
        if (exp_q.size() == 0) begin
          check("unexpected_retire", 64'(retire), 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_en", 64'(wr_en), 64'(e.en));
          check("wr_addr", 64'(wr_addr), 64'(e.addr));
          check("wr_data", 64'(wr_data), 64'(e.data));
        end
      end else begin
        check("wr_en_idle", 64'(wr_en), 64'd0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction; called just after a rising edge, returns just after the accepting edge.
  task automatic send(input logic ld, input logic [2:0] f3, input logic [1:0] off, input logic rw,
                      input logic [4:0] rd, input logic [XLEN-1:0] res, input logic exp_ret);
    in_valid = 1'b1; in_is_load = ld; in_funct3 = f3; in_byte_off = off;
    in_reg_wr = rw; in_rd = rd; in_result = res;
    @(negedge clk);
    check("in_ready_at_accept", 64'(in_ready), 64'd1);
    check("retire_at_accept", 64'(retire), 64'(exp_ret));
    cyc();
    in_valid = 1'b0; in_is_load = 1'b0; mem_rsp_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [XLEN-1:0] res, input logic rw, input logic exp_en);
    exp_q.push_back('{en: exp_en, addr: rd, data: res});
    send(1'b0, 3'b000, 2'b00, rw, rd, res, 1'b0);
    @(negedge clk);
    check("alu_latency", 64'(retire), 64'd1);
    cyc();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                         input logic [XLEN-1:0] word, input logic [XLEN-1:0] exp_d,
                         input int delay, input logic rsp_early);
    exp_q.push_back('{en: 1'b1, addr: rd, data: exp_d});
    mem_rsp_valid = rsp_early;
    mem_rsp_data  = 32'hBAD0_BAD0;
    send(1'b1, f3, off, 1'b1, rd, 32'h0BAD_0BAD, 1'b0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("load_wait_ready", 64'(in_ready), 64'd0);
      check("load_wait_retire", 64'(retire), 64'd0);
      cyc();
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = word;
    @(negedge clk);
    check("load_rsp_ready", 64'(in_ready), 64'd0);
    cyc();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    @(negedge clk);
    check("load_latency", 64'(retire), 64'd1);
    check("load_commit_ready", 64'(in_ready), 64'd1);
    cyc();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_is_load = 1'b0; in_funct3 = '0; in_byte_off = '0;
    in_reg_wr = 1'b0; in_rd = '0; in_result = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_instret", instret, 64'd0);
    cyc();

    // Single non-load
    alu(5'd5, 32'h0000_1234, 1'b1, 1'b1);
    check("t1_instret", instret, 64'd1);

    // Back-to-back non-loads retire on consecutive cycles
    exp_q.push_back('{en: 1'b1, addr: 5'd1, data: 32'h1111_0001});
    exp_q.push_back('{en: 1'b1, addr: 5'd2, data: 32'h2222_0002});
    exp_q.push_back('{en: 1'b1, addr: 5'd3, data: 32'h3333_0003});
    send(1'b0, 3'b000, 2'b00, 1'b1, 5'd1, 32'h1111_0001, 1'b0);
    send(1'b0, 3'b000, 2'b00, 1'b1, 5'd2, 32'h2222_0002, 1'b1);
    send(1'b0, 3'b000, 2'b00, 1'b1, 5'd3, 32'h3333_0003, 1'b1);
    @(negedge clk);
    check("t2_third_retire", 64'(retire), 64'd1);
    check("t2_instret", instret, 64'd4);
    cyc();

    // Byte loads; the LBU carries a response pulse in its accept cycle that must be ignored
    do_load(3'b000, 2'd3, 5'd10, 32'h80FF_0000, 32'hFFFF_FF80, 4, 1'b0);
    do_load(3'b100, 2'd3, 5'd11, 32'h80FF_0000, 32'h0000_0080, 4, 1'b1);
    do_load(3'b000, 2'd2, 5'd12, 32'h80FF_0000, 32'hFFFF_FFFF, 1, 1'b0);
    do_load(3'b100, 2'd1, 5'd13, 32'h80FF_0000, 32'h0000_0000, 0, 1'b0);

    // Halfword / word loads, including off[0] ignored and funct3 011 as LW
    do_load(3'b001, 2'd2, 5'd14, 32'h8001_7FFF, 32'hFFFF_8001, 2, 1'b0);
    do_load(3'b101, 2'd0, 5'd15, 32'h8001_7FFF, 32'h0000_7FFF, 0, 1'b0);
    do_load(3'b010, 2'd1, 5'd16, 32'h8001_7FFF, 32'h8001_7FFF, 1, 1'b0);
    do_load(3'b011, 2'd0, 5'd17, 32'h8001_7FFF, 32'h8001_7FFF, 0, 1'b0);
    do_load(3'b001, 2'd3, 5'd18, 32'h8001_7FFF, 32'hFFFF_8001, 0, 1'b0);
    check("t4_instret", instret, 64'd13);

    // Stray response while idle must not retire anything
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF;
    cyc();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stray_rsp_retire", 64'(retire), 64'd0);
    cyc();

    // x0 destination and reg_wr=0 still retire but never write
    alu(5'd0, 32'h0000_DEAD, 1'b1, 1'b0);
    alu(5'd7, 32'h0000_0077, 1'b0, 1'b0);
    check("t5_instret", instret, 64'd15);

    // Reset while a load waits: load dropped, late response ignored
    send(1'b1, 3'b010, 2'b00, 1'b1, 5'd9, 32'h0, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    model_cnt = 0;
    cyc();
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
    @(negedge clk);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_instret", instret, 64'd0);
    cyc();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("t6_late_rsp_retire", 64'(retire), 64'd0);
    check("t6_late_rsp_wr_en", 64'(wr_en), 64'd0);
    check("t6_instret_after", instret, 64'd0);
    cyc();
    alu(5'd4, 32'h0000_0055, 1'b1, 1'b1);
    check("t6_resume_instret", instret, 64'd1);

    repeat (2) cyc();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
